// File: rtl/inv_sub_bytes_engine_pkg.sv
// Shared AES constants, engine FSM encoding and GF(2^8) helpers for the
// inverse S-box path.
package inv_sub_bytes_engine_pkg;

    localparam int unsigned AES_STATE_W   = 128;
    localparam int unsigned AES_BYTE_W    = 8;
    localparam int unsigned AES_NUM_BYTES = AES_STATE_W / AES_BYTE_W;

    localparam logic [AES_BYTE_W-1:0] AES_INV_AFFINE_C = 8'h05;
    localparam logic [AES_BYTE_W-1:0] AES_FWD_AFFINE_C = 8'h63;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } eng_state_e;

    // Product modulo x^8+x^4+x^3+x+1 (shift-and-add).
    function automatic logic [AES_BYTE_W-1:0] gf_mul(
        input logic [AES_BYTE_W-1:0] a,
        input logic [AES_BYTE_W-1:0] b
    );
        logic [AES_BYTE_W-1:0] p;
        logic [AES_BYTE_W-1:0] aa;
        logic [AES_BYTE_W-1:0] bb;
        p  = '0;
        aa = a;
        bb = b;
        for (int i = 0; i < 8; i++) begin
            if (bb[0]) begin
                p = p ^ aa;
            end
            bb = bb >> 1;
            aa = aa[7] ? ({aa[6:0], 1'b0} ^ 8'h1b) : {aa[6:0], 1'b0};
        end
        return p;
    endfunction

    // Multiplicative inverse as x^254; maps 0 to 0 without a special case.
    function automatic logic [AES_BYTE_W-1:0] gf_inv(input logic [AES_BYTE_W-1:0] x);
        logic [AES_BYTE_W-1:0] sq;
        logic [AES_BYTE_W-1:0] r;
        sq = x;
        r  = 8'h01;
        for (int i = 1; i < 8; i++) begin
            sq = gf_mul(sq, sq);
            r  = gf_mul(r, sq);
        end
        return r;
    endfunction

    // y[i] = x[i+2] ^ x[i+5] ^ x[i+7] ^ c[i], indices mod 8, as right rotations.
    function automatic logic [AES_BYTE_W-1:0] inv_affine(input logic [AES_BYTE_W-1:0] x);
        return {x[1:0], x[7:2]} ^ {x[4:0], x[7:5]} ^ {x[6:0], x[7]} ^ AES_INV_AFFINE_C;
    endfunction

endpackage

// File: rtl/inv_sub_bytes_engine_inv_s_box.sv
// One combinational inverse S-box lane: inverse affine map, then GF(2^8) inverse.
module inv_s_box
    import inv_sub_bytes_engine_pkg::*;
(
    input  logic [AES_BYTE_W-1:0] byte_i,
    output logic [AES_BYTE_W-1:0] byte_o
);

    always_comb begin
        byte_o = gf_inv(inv_affine(byte_i));
    end

endmodule

// File: rtl/inv_sub_bytes_engine.sv
// Iterative AES InvSubBytes: loads a 128-bit state, substitutes BYTES_PER_CYCLE
// bytes per clock (lowest group first), then holds the result until taken.
module inv_sub_bytes_engine
    import inv_sub_bytes_engine_pkg::*;
#(
    parameter int unsigned BYTES_PER_CYCLE = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [AES_STATE_W-1:0] in_state,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [AES_STATE_W-1:0] out_state,
    output logic                   busy
);

    localparam int unsigned NUM_GROUPS = AES_NUM_BYTES / BYTES_PER_CYCLE;
    localparam int unsigned CNT_W      = (NUM_GROUPS > 1) ? $clog2(NUM_GROUPS) : 1;
    localparam int unsigned GROUP_W    = BYTES_PER_CYCLE * AES_BYTE_W;
    localparam int unsigned SHIFT_W    = $clog2(AES_STATE_W);

    localparam logic [CNT_W-1:0]   LAST_GROUP = CNT_W'(NUM_GROUPS - 1);
    localparam logic [GROUP_W-1:0] GROUP_MASK = {GROUP_W{1'b1}};

    generate
        if (!(BYTES_PER_CYCLE == 1 || BYTES_PER_CYCLE == 2 || BYTES_PER_CYCLE == 4 ||
              BYTES_PER_CYCLE == 8 || BYTES_PER_CYCLE == 16)) begin : g_bad_param
            $error("inv_sub_bytes_engine: BYTES_PER_CYCLE must be 1, 2, 4, 8 or 16");
        end
    endgenerate

    eng_state_e             state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [AES_STATE_W-1:0] work_q, work_d;
    logic [AES_STATE_W-1:0] out_state_q, out_state_d;
    logic                   in_ready_q, in_ready_d;
    logic                   out_valid_q, out_valid_d;
    logic                   busy_q, busy_d;

    logic [SHIFT_W-1:0]     grp_shift;
    logic [GROUP_W-1:0]     grp_in;
    logic [GROUP_W-1:0]     grp_out;
    logic [AES_STATE_W-1:0] work_merged;

    // Counter-indexed byte-group mux feeding the lanes, and write-back of the lane results.
    always_comb begin
        grp_shift   = SHIFT_W'(cnt_q) * SHIFT_W'(GROUP_W);
        grp_in      = GROUP_W'(work_q >> grp_shift);
        work_merged = (work_q & ~(AES_STATE_W'(GROUP_MASK) << grp_shift))
                    | (AES_STATE_W'(grp_out) << grp_shift);
    end

    for (genvar l = 0; l < BYTES_PER_CYCLE; l++) begin : g_lane
        inv_s_box u_inv_s_box (
            .byte_i (grp_in [l*AES_BYTE_W +: AES_BYTE_W]),
            .byte_o (grp_out[l*AES_BYTE_W +: AES_BYTE_W])
        );
    end

    // Next-state logic; registered outputs are derived from the next state.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        work_d      = work_q;
        out_state_d = out_state_q;

        unique case (state_q)
            IDLE: begin
                if (in_valid && in_ready_q) begin
                    work_d  = in_state;
                    cnt_d   = '0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                work_d = work_merged;
                cnt_d  = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_GROUP) begin
                    out_state_d = work_merged;
                    state_d     = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        in_ready_d  = (state_d == IDLE);
        out_valid_d = (state_d == DONE);
        busy_d      = (state_d == BUSY);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            work_q      <= '0;
            out_state_q <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            work_q      <= work_d;
            out_state_q <= out_state_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_state = out_state_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_inv_sub_bytes_engine.sv
// Directed and round-trip bench for inv_sub_bytes_engine at 1, 4 and 16 lanes.
module tb_inv_sub_bytes_engine;

    logic         clk;
    logic         rst;
    logic         in_valid  [3];
    logic         in_ready  [3];
    logic [127:0] in_state  [3];
    logic         out_valid [3];
    logic         out_ready [3];
    logic [127:0] out_state [3];
    logic         busy      [3];

    int errors;
    int checks;
    logic [7:0] sbox [256];

    localparam logic [127:0] ROW_IN  = 128'h76ABD7FE2B670130C56F6BF27B777C63;
    localparam logic [127:0] ROW_OUT = 128'h0F0E0D0C0B0A09080706050403020100;
    localparam logic [127:0] PAT_IN  = {4{32'hED160100}};
    localparam logic [127:0] PAT_OUT = {4{32'h53FF0952}};
    localparam logic [127:0] ALL63   = {16{8'h63}};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    inv_sub_bytes_engine #(.BYTES_PER_CYCLE(1)) u_dut1 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_state(in_state[0]),
        .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_state(out_state[0]),
        .busy(busy[0])
    );

    inv_sub_bytes_engine #(.BYTES_PER_CYCLE(4)) u_dut4 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_state(in_state[1]),
        .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_state(out_state[1]),
        .busy(busy[1])
    );

    inv_sub_bytes_engine #(.BYTES_PER_CYCLE(16)) u_dut16 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid[2]), .in_ready(in_ready[2]), .in_state(in_state[2]),
        .out_valid(out_valid[2]), .out_ready(out_ready[2]), .out_state(out_state[2]),
        .busy(busy[2])
    );

    function automatic int exp_lat(input int d);
        if (d == 0) return 17;
        if (d == 1) return 5;
        return 2;
    endfunction

    function automatic logic [7:0] tb_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        logic [7:0] y;
        p = 8'h00;
        x = a;
        y = b;
        for (int i = 0; i < 8; i++) begin
            if (x[0]) p = p ^ y;
            x = x >> 1;
            y = y[7] ? ({y[6:0], 1'b0} ^ 8'h1b) : {y[6:0], 1'b0};
        end
        return p;
    endfunction

    // Forward S-box table built by exhaustive inverse search and forward affine.
    task automatic build_sbox();
        logic [7:0] inv;
        logic [7:0] v;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++) begin
                if (tb_mul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            end
            v = inv;
            sbox[x] = v ^ {v[3:0], v[7:4]} ^ {v[4:0], v[7:5]} ^ {v[5:0], v[7:6]}
                        ^ {v[6:0], v[7]} ^ 8'h63;
        end
    endtask

    function automatic logic [127:0] fwd_state(input logic [127:0] s);
        logic [127:0] r;
        for (int k = 0; k < 16; k++) begin
            r[k*8 +: 8] = sbox[s[k*8 +: 8]];
        end
        return r;
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // Starts at #1 after an edge with the DUT idle; in_state is scrambled after accept.
    task automatic run_txn(input int d, input logic [127:0] st,
                           output logic [127:0] res, output int lat);
        in_valid[d] = 1'b1;
        in_state[d] = st;
        @(posedge clk); #1;
        in_valid[d] = 1'b0;
        in_state[d] = rnd128();
        lat = 1;
        while (!out_valid[d] && lat < 200) begin
            @(posedge clk); #1;
            in_state[d] = rnd128();
            lat++;
        end
        res = out_state[d];
        out_ready[d] = 1'b1;
        @(posedge clk); #1;
        out_ready[d] = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < 3; d++) begin
            checks++;
            if (in_ready[d] !== 1'b1) begin
                errors++; $display("FAIL reset_in_ready[%0d]: got %b want 1", d, in_ready[d]);
            end
            checks++;
            if (out_valid[d] !== 1'b0) begin
                errors++; $display("FAIL reset_out_valid[%0d]: got %b want 0", d, out_valid[d]);
            end
            checks++;
            if (busy[d] !== 1'b0) begin
                errors++; $display("FAIL reset_busy[%0d]: got %b want 0", d, busy[d]);
            end
            checks++;
            if (out_state[d] !== 128'h0) begin
                errors++; $display("FAIL reset_out_state[%0d]: got %h want 0", d, out_state[d]);
            end
        end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_all63();
        logic [127:0] res;
        int lat;
        run_txn(1, ALL63, res, lat);
        checks++;
        if (lat !== 5) begin
            errors++; $display("FAIL all63_latency: got %0d want 5", lat);
        end
        checks++;
        if (res !== 128'h0) begin
            errors++; $display("FAIL all63_result: got %h want 0", res);
        end
    endtask

    task automatic test_pattern();
        logic [127:0] res;
        int lat;
        for (int d = 0; d < 3; d++) begin
            run_txn(d, PAT_IN, res, lat);
            checks++;
            if (res !== PAT_OUT) begin
                errors++; $display("FAIL pattern[%0d]: got %h want %h", d, res, PAT_OUT);
            end
        end
    endtask

    task automatic test_byte_order();
        logic [127:0] res;
        int lat;
        for (int d = 0; d < 3; d++) begin
            run_txn(d, ROW_IN, res, lat);
            checks++;
            if (res !== ROW_OUT) begin
                errors++; $display("FAIL byte_order[%0d]: got %h want %h", d, res, ROW_OUT);
            end
            checks++;
            if (lat !== exp_lat(d)) begin
                errors++; $display("FAIL latency[%0d]: got %0d want %0d", d, lat, exp_lat(d));
            end
        end
    endtask

    task automatic test_backpressure();
        int busy_cnt;
        int n;
        in_valid[1] = 1'b1;
        in_state[1] = ROW_IN;
        @(posedge clk); #1;
        in_valid[1] = 1'b0;
        busy_cnt = 0;
        n = 0;
        while (!out_valid[1] && n < 50) begin
            if (busy[1] === 1'b1) busy_cnt++;
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (busy_cnt !== 4) begin
            errors++; $display("FAIL busy_cycles: got %0d want 4", busy_cnt);
        end
        checks++;
        if (busy[1] !== 1'b0) begin
            errors++; $display("FAIL busy_in_done: got %b want 0", busy[1]);
        end
        for (int c = 0; c < 10; c++) begin
            checks++;
            if (out_valid[1] !== 1'b1) begin
                errors++; $display("FAIL bp_out_valid c%0d: got %b want 1", c, out_valid[1]);
            end
            checks++;
            if (out_state[1] !== ROW_OUT) begin
                errors++; $display("FAIL bp_out_state c%0d: got %h want %h", c, out_state[1], ROW_OUT);
            end
            checks++;
            if (in_ready[1] !== 1'b0) begin
                errors++; $display("FAIL bp_in_ready c%0d: got %b want 0", c, in_ready[1]);
            end
            @(posedge clk); #1;
        end
        out_ready[1] = 1'b1;
        @(posedge clk); #1;
        out_ready[1] = 1'b0;
        checks++;
        if (out_valid[1] !== 1'b0) begin
            errors++; $display("FAIL bp_release_out_valid: got %b want 0", out_valid[1]);
        end
        checks++;
        if (in_ready[1] !== 1'b1) begin
            errors++; $display("FAIL bp_release_in_ready: got %b want 1", in_ready[1]);
        end
    endtask

    task automatic test_reset_mid();
        logic [127:0] res;
        int lat;
        in_valid[1] = 1'b1;
        in_state[1] = PAT_IN;
        @(posedge clk); #1;
        in_valid[1] = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checks++;
        if (in_ready[1] !== 1'b1) begin
            errors++; $display("FAIL midrst_in_ready: got %b want 1", in_ready[1]);
        end
        checks++;
        if (out_valid[1] !== 1'b0) begin
            errors++; $display("FAIL midrst_out_valid: got %b want 0", out_valid[1]);
        end
        checks++;
        if (busy[1] !== 1'b0) begin
            errors++; $display("FAIL midrst_busy: got %b want 0", busy[1]);
        end
        checks++;
        if (out_state[1] !== 128'h0) begin
            errors++; $display("FAIL midrst_out_state: got %h want 0", out_state[1]);
        end
        run_txn(1, ROW_IN, res, lat);
        checks++;
        if (res !== ROW_OUT) begin
            errors++; $display("FAIL midrst_next_result: got %h want %h", res, ROW_OUT);
        end
        checks++;
        if (lat !== 5) begin
            errors++; $display("FAIL midrst_next_latency: got %0d want 5", lat);
        end
    endtask

    task automatic test_input_change();
        logic [127:0] res;
        int lat;
        // run_txn drives a fresh random in_state on every cycle after the accept edge.
        for (int d = 0; d < 3; d++) begin
            run_txn(d, PAT_IN, res, lat);
            checks++;
            if (res !== PAT_OUT) begin
                errors++; $display("FAIL input_change[%0d]: got %h want %h", d, res, PAT_OUT);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [127:0] res_a;
        logic [127:0] res_b;
        logic         prev_rdy;
        logic         got_a;
        int n;
        in_valid[1]  = 1'b1;
        in_state[1]  = ALL63;
        out_ready[1] = 1'b1;
        @(posedge clk); #1;
        in_state[1] = ROW_IN;
        n = 0;
        got_a = 1'b0;
        res_a = '0;
        prev_rdy = 1'b0;
        while (n < 40) begin
            if (out_valid[1] && !got_a) begin
                res_a = out_state[1];
                got_a = 1'b1;
            end
            prev_rdy = in_ready[1];
            @(posedge clk); #1;
            n++;
            if (prev_rdy) break;
        end
        in_valid[1] = 1'b0;
        checks++;
        if (n !== 6) begin
            errors++; $display("FAIL b2b_accept_spacing: got %0d want 6", n);
        end
        checks++;
        if (res_a !== 128'h0) begin
            errors++; $display("FAIL b2b_first_result: got %h want 0", res_a);
        end
        n = 0;
        while (!out_valid[1] && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        res_b = out_state[1];
        @(posedge clk); #1;
        out_ready[1] = 1'b0;
        checks++;
        if (res_b !== ROW_OUT) begin
            errors++; $display("FAIL b2b_second_result: got %h want %h", res_b, ROW_OUT);
        end
        checks++;
        if (in_ready[1] !== 1'b1) begin
            errors++; $display("FAIL b2b_final_in_ready: got %b want 1", in_ready[1]);
        end
    endtask

    task automatic test_round_trip();
        logic [127:0] x;
        logic [127:0] res;
        int lat;
        for (int d = 0; d < 3; d++) begin
            for (int v = 0; v < 1000; v++) begin
                x = rnd128();
                run_txn(d, fwd_state(x), res, lat);
                checks++;
                if (res !== x) begin
                    errors++; $display("FAIL round_trip[%0d] v%0d: got %h want %h", d, v, res, x);
                end
                checks++;
                if (lat !== exp_lat(d)) begin
                    errors++; $display("FAIL round_trip_lat[%0d] v%0d: got %0d want %0d", d, v, lat, exp_lat(d));
                end
            end
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst = 1'b1;
        for (int d = 0; d < 3; d++) begin
            in_valid[d]  = 1'b0;
            in_state[d]  = '0;
            out_ready[d] = 1'b0;
        end
        build_sbox();
        test_reset();
        test_all63();
        test_pattern();
        test_byte_order();
        test_backpressure();
        test_reset_mid();
        test_input_change();
        test_back_to_back();
        test_round_trip();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
